alu_share_arbiter: RTL and testbench
====================================

// Module: alu_share_arbiter
// PURPOSE
//  Shares one combinational execute-stage ALU among NREQ requesters (e.g. main pipe, branch-target
//  calc, debug/test port). Round-robin grant on valid/ready; drives the ALU operand/select ports
//  from the winner. Captures the ALU result with the winner's ID into a one-entry response register
//  that is drained on a valid/ready handshake. Sits between requesters and the ALU in execute.
// PARAMETERS
//  NREQ    2   number of requesters (2..8)
//  DWIDTH  32  operand/result width
//  AWIDTH  32  PC width
//  IDW     $clog2(NREQ) (min 1)  requester ID width (derived localparam)
// PORTS
//  clk           in   1            clock, all state on rising edge
//  reset         in   1            asynchronous, active-low reset
//  req_valid_i   in   NREQ         requester i has an operation pending
//  req_ready_o   out  NREQ         one-hot or zero; bit i = request i accepted this cycle
//  req_pc_i      in   NREQ*AWIDTH  packed PCs, slice i = [i*AWIDTH +: AWIDTH]
//  req_rs1_i     in   NREQ*DWIDTH  packed operand 1
//  req_rs2_i     in   NREQ*DWIDTH  packed operand 2
//  req_alusel_i  in   NREQ*4       packed ALU select codes (ADD..PCADD)
//  alu_pc_o      out  AWIDTH       to ALU pc_i (winner's slice, else 0)
//  alu_rs1_o     out  DWIDTH       to ALU rs1_i
//  alu_rs2_o     out  DWIDTH       to ALU rs2_i
//  alu_alusel_o  out  4            to ALU alusel_i (ADD when idle)
//  alu_res_i     in   DWIDTH       from ALU res_o (combinational)
//  resp_valid_o  out  1            response register holds a result
//  resp_ready_i  in   1            consumer accepts response
//  resp_id_o     out  IDW          requester index owning the response
//  resp_res_o    out  DWIDTH       captured ALU result
//  busy_cnt_o    out  32           count of cycles with a grant (saturating)
// BEHAVIOUR
//  - Reset: resp_valid_o=0, resp_id_o=0, resp_res_o=0, rr pointer=0, busy_cnt_o=0;
//    req_ready_o=0 while reset asserted. Reset mid-transaction discards the held response.
//  - can_issue = !resp_valid_o || resp_ready_i (response slot empty or draining this cycle).
//  - Grant (combinational): if can_issue, winner = first i with req_valid_i[i] scanning
//    ptr, ptr+1, ... wrapping mod NREQ. req_ready_o = onehot(winner), else 0.
//  - ALU outputs mux winner's slices; with no grant drive pc/rs1/rs2=0, alusel=ADD.
//  - On grant edge: resp_res_o<=alu_res_i, resp_id_o<=winner, resp_valid_o<=1,
//    ptr<=(winner+1) mod NREQ (wrap NREQ-1 -> 0), busy_cnt_o+=1 (hold at 2^32-1).
//  - No grant and resp_valid_o&&resp_ready_i: resp_valid_o<=0; ptr unchanged.
//  - Simultaneous drain+grant: new result replaces old in same edge, resp_valid_o stays 1;
//    full throughput one op/cycle. Latency: request accept -> resp_valid_o next cycle.
//  - Backpressure: resp_valid_o && !resp_ready_i => all req_ready_o=0; resp_* held stable.
//  - req_ready_o never depends on req_valid_i of the same index combinationally looping back;
//    requesters must hold valid and operands stable until ready (AXI-style, no retraction).
//  - Non-granted requests never lose data; fairness: a continuously valid requester is granted
//    within NREQ grants.
//  - Unused alusel codes pass through; ALU default (ADD) applies.
// TESTING
//  1 Reset: hold reset=0 with req_valid_i=2'b11 -> req_ready_o=0, resp_valid_o=0; release ->
//    first grant to req 0 (ptr=0).
//  2 Single op: req1 ADD rs1=5 rs2=7 -> ready[1]=1 that cycle; next cycle resp_valid_o=1,
//    resp_id_o=1, resp_res_o=12.
//  3 Round-robin: both valid every cycle, resp_ready_i=1 -> grants 0,1,0,1; busy_cnt_o=4
//    after 4 cycles; one response per cycle.
//  4 Backpressure: resp valid, resp_ready_i=0 for 3 cycles -> req_ready_o=0, resp_res_o stable;
//    raise resp_ready_i -> drain and new grant in same cycle.
//  5 PCADD/SRA: req0 PCADD pc=0x100 rs2=0x20 -> 0x120; req1 SRA rs1=0x80000000 rs2=4
//    -> 0xF8000000 with correct IDs.
//  6 Async reset mid-op: assert reset between clock edges with resp_valid_o=1 ->
//    resp_valid_o drops immediately, ptr=0.

Source files
------------

// File: rtl/alu_share_arbiter_if.sv
// Requester, ALU-side and response signals of the shared execute ALU arbiter.
// slave = arbiter view, master = environment (requesters, ALU, consumer) view.
interface alu_share_arbiter_if #(
    parameter int NREQ   = 2,
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 32
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]        req_valid_i;
    logic [NREQ-1:0]        req_ready_o;
    logic [NREQ*AWIDTH-1:0] req_pc_i;
    logic [NREQ*DWIDTH-1:0] req_rs1_i;
    logic [NREQ*DWIDTH-1:0] req_rs2_i;
    logic [NREQ*4-1:0]      req_alusel_i;

    logic [AWIDTH-1:0]      alu_pc_o;
    logic [DWIDTH-1:0]      alu_rs1_o;
    logic [DWIDTH-1:0]      alu_rs2_o;
    logic [3:0]             alu_alusel_o;
    logic [DWIDTH-1:0]      alu_res_i;

    logic                   resp_valid_o;
    logic                   resp_ready_i;
    logic [IDW-1:0]         resp_id_o;
    logic [DWIDTH-1:0]      resp_res_o;
    logic [31:0]            busy_cnt_o;

    modport slave (
        input  req_valid_i, req_pc_i, req_rs1_i, req_rs2_i, req_alusel_i,
        input  alu_res_i, resp_ready_i,
        output req_ready_o, alu_pc_o, alu_rs1_o, alu_rs2_o, alu_alusel_o,
        output resp_valid_o, resp_id_o, resp_res_o, busy_cnt_o
    );

    modport master (
        output req_valid_i, req_pc_i, req_rs1_i, req_rs2_i, req_alusel_i,
        output alu_res_i, resp_ready_i,
        input  req_ready_o, alu_pc_o, alu_rs1_o, alu_rs2_o, alu_alusel_o,
        input  resp_valid_o, resp_id_o, resp_res_o, busy_cnt_o
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one combinational ALU among NREQ requesters, with a
// one-entry response register (result + owner ID) drained on valid/ready.
module alu_share_arbiter #(
    parameter int NREQ   = 2,
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 32
) (
    input logic                clk,
    input logic                reset,
    alu_share_arbiter_if.slave bus
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [3:0] ALU_ADD = 4'd0;

    logic [IDW-1:0]    ptr;
    logic [IDW-1:0]    winner;
    logic              grant_vld;
    logic              can_issue;
    logic [IDW:0]      cand;

    logic              resp_valid;
    logic [IDW-1:0]    resp_id;
    logic [DWIDTH-1:0] resp_res;
    logic [31:0]       busy_cnt;

    // Gated by reset so no request is accepted while reset is held.
    assign can_issue = reset && (!resp_valid || bus.resp_ready_i);

    always_comb begin
        grant_vld = 1'b0;
        winner    = '0;
        cand      = '0;
        if (can_issue) begin
            for (int unsigned k = 0; k < NREQ; k++) begin
                cand = {1'b0, ptr} + (IDW+1)'(k);
                if (cand >= (IDW+1)'(NREQ))
                    cand = cand - (IDW+1)'(NREQ);
                if (!grant_vld && bus.req_valid_i[cand[IDW-1:0]]) begin
                    grant_vld = 1'b1;
                    winner    = cand[IDW-1:0];
                end
            end
        end
    end

    always_comb begin
        bus.req_ready_o  = '0;
        bus.alu_pc_o     = '0;
        bus.alu_rs1_o    = '0;
        bus.alu_rs2_o    = '0;
        bus.alu_alusel_o = ALU_ADD;
        if (grant_vld) begin
            bus.req_ready_o[winner] = 1'b1;
            bus.alu_pc_o     = bus.req_pc_i[int'(winner)*AWIDTH +: AWIDTH];
            bus.alu_rs1_o    = bus.req_rs1_i[int'(winner)*DWIDTH +: DWIDTH];
            bus.alu_rs2_o    = bus.req_rs2_i[int'(winner)*DWIDTH +: DWIDTH];
            bus.alu_alusel_o = bus.req_alusel_i[int'(winner)*4 +: 4];
        end
    end

    // A grant implies the slot is empty or draining, so the new result overwrites in place.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            resp_valid <= 1'b0;
            resp_id    <= '0;
            resp_res   <= '0;
            ptr        <= '0;
            busy_cnt   <= '0;
        end else if (grant_vld) begin
            resp_valid <= 1'b1;
            resp_id    <= winner;
            resp_res   <= bus.alu_res_i;
            ptr        <= (winner == IDW'(NREQ-1)) ? '0 : winner + 1'b1;
            if (busy_cnt != '1)
                busy_cnt <= busy_cnt + 32'd1;
        end else if (resp_valid && bus.resp_ready_i) begin
            resp_valid <= 1'b0;
        end
    end

    assign bus.resp_valid_o = resp_valid;
    assign bus.resp_id_o    = resp_id;
    assign bus.resp_res_o   = resp_res;
    assign bus.busy_cnt_o   = busy_cnt;
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with two requesters and a behavioural ALU.
module tb_alu_share_arbiter;
    localparam int NREQ = 2;
    localparam int DW   = 32;
    localparam int AW   = 32;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    alu_share_arbiter_if #(.NREQ(NREQ), .DWIDTH(DW), .AWIDTH(AW)) bus ();

    alu_share_arbiter #(.NREQ(NREQ), .DWIDTH(DW), .AWIDTH(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Behavioural ALU; unknown select codes fall back to ADD.
    always_comb begin
        case (bus.alu_alusel_o)
            4'd1:    bus.alu_res_i = bus.alu_rs1_o - bus.alu_rs2_o;
            4'd5:    bus.alu_res_i = bus.alu_rs1_o ^ bus.alu_rs2_o;
            4'd7:    bus.alu_res_i = 32'($signed(bus.alu_rs1_o) >>> bus.alu_rs2_o[4:0]);
            4'd10:   bus.alu_res_i = bus.alu_pc_o + bus.alu_rs2_o;
            default: bus.alu_res_i = bus.alu_rs1_o + bus.alu_rs2_o;
        endcase
    end

    typedef struct {
        logic [1:0]  valid;
        logic [3:0]  sel0;
        logic [31:0] pc0, a0, b0;
        logic [3:0]  sel1;
        logic [31:0] a1, b1;
        logic [1:0]  exp_ready;
        logic [3:0]  exp_sel;
        logic        exp_rvalid;
        logic        exp_id;
        logic [31:0] exp_res;
    } vec_t;

    vec_t vecs[13];

    function automatic vec_t mk(input logic [1:0] v,
                                input logic [3:0] s0, input logic [31:0] p0, a0, b0,
                                input logic [3:0] s1, input logic [31:0] a1, b1,
                                input logic [1:0] er, input logic [3:0] es,
                                input logic erv, input logic eid, input logic [31:0] eres);
        vec_t t;
        t.valid = v; t.sel0 = s0; t.pc0 = p0; t.a0 = a0; t.b0 = b0;
        t.sel1 = s1; t.a1 = a1; t.b1 = b1;
        t.exp_ready = er; t.exp_sel = es; t.exp_rvalid = erv; t.exp_id = eid; t.exp_res = eres;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] v,
                         input logic [3:0] s0, input logic [31:0] p0, a0, b0,
                         input logic [3:0] s1, input logic [31:0] a1, b1);
        bus.req_valid_i  = v;
        bus.req_alusel_i = {s1, s0};
        bus.req_pc_i     = {32'h0000_0200, p0};
        bus.req_rs1_i    = {a1, a0};
        bus.req_rs2_i    = {b1, b0};
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        // ptr sequence: 0,1,0(V2 skip->1),0,1,0,1,0,1,0,1(idle),1,0
        vecs[0]  = mk(2'b11, 4'd0, 0, 1, 2,                   4'd1, 10, 3,  2'b01, 4'd0,  1, 0, 32'd3);
        vecs[1]  = mk(2'b10, 4'd0, 0, 1, 2,                   4'd1, 10, 3,  2'b10, 4'd1,  1, 1, 32'd7);
        vecs[2]  = mk(2'b10, 4'd0, 0, 1, 2,                   4'd0, 5, 7,   2'b10, 4'd0,  1, 1, 32'd12);
        vecs[3]  = mk(2'b11, 4'd5, 0, 32'hF0F0, 32'h0FF0,     4'd1, 10, 3,  2'b01, 4'd5,  1, 0, 32'hFF00);
        vecs[4]  = mk(2'b11, 4'd5, 0, 32'hF0F0, 32'h0FF0,     4'd1, 10, 3,  2'b10, 4'd1,  1, 1, 32'd7);
        vecs[5]  = mk(2'b11, 4'd5, 0, 32'hF0F0, 32'h0FF0,     4'd1, 10, 3,  2'b01, 4'd5,  1, 0, 32'hFF00);
        vecs[6]  = mk(2'b11, 4'd5, 0, 32'hF0F0, 32'h0FF0,     4'd1, 10, 3,  2'b10, 4'd1,  1, 1, 32'd7);
        vecs[7]  = mk(2'b01, 4'd10, 32'h100, 0, 32'h20,       4'd0, 0, 0,   2'b01, 4'd10, 1, 0, 32'h120);
        vecs[8]  = mk(2'b10, 4'd0, 0, 0, 0,                   4'd7, 32'h8000_0000, 4, 2'b10, 4'd7, 1, 1, 32'hF800_0000);
        vecs[9]  = mk(2'b01, 4'd15, 0, 3, 4,                  4'd0, 0, 0,   2'b01, 4'd15, 1, 0, 32'd7);
        vecs[10] = mk(2'b00, 4'd0, 0, 0, 0,                   4'd0, 0, 0,   2'b00, 4'd0,  0, 0, 32'd7);
        vecs[11] = mk(2'b11, 4'd0, 0, 1, 2,                   4'd0, 100, 200, 2'b10, 4'd0, 1, 1, 32'd300);
        vecs[12] = mk(2'b01, 4'd0, 0, 1, 2,                   4'd0, 0, 0,   2'b01, 4'd0,  1, 0, 32'd3);

        // Reset held with both requesters valid
        bus.resp_ready_i = 1'b1;
        drive(2'b11, 4'd0, 0, 1, 2, 4'd1, 10, 3);
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 32'(bus.req_ready_o), 32'd0);
        check("rst_rvalid", 32'(bus.resp_valid_o), 32'd0);
        check("rst_id", 32'(bus.resp_id_o), 32'd0);
        check("rst_res", bus.resp_res_o, 32'd0);
        check("rst_busy", bus.busy_cnt_o, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i].valid, vecs[i].sel0, vecs[i].pc0, vecs[i].a0, vecs[i].b0,
                  vecs[i].sel1, vecs[i].a1, vecs[i].b1);
            #1;
            check($sformatf("v%0d_ready", i), 32'(bus.req_ready_o), 32'(vecs[i].exp_ready));
            check($sformatf("v%0d_alusel", i), 32'(bus.alu_alusel_o), 32'(vecs[i].exp_sel));
            @(posedge clk);
            #1;
            check($sformatf("v%0d_rvalid", i), 32'(bus.resp_valid_o), 32'(vecs[i].exp_rvalid));
            check($sformatf("v%0d_id", i), 32'(bus.resp_id_o), 32'(vecs[i].exp_id));
            check($sformatf("v%0d_res", i), bus.resp_res_o, vecs[i].exp_res);
            @(negedge clk);
        end
        check("busy_after_table", bus.busy_cnt_o, 32'd12);

        // Backpressure: slot holds id0/3, ptr=1
        bus.resp_ready_i = 1'b0;
        drive(2'b11, 4'd0, 0, 1, 2, 4'd0, 100, 200);
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("bp%0d_ready", i), 32'(bus.req_ready_o), 32'd0);
            @(posedge clk);
            #1;
            check($sformatf("bp%0d_rvalid", i), 32'(bus.resp_valid_o), 32'd1);
            check($sformatf("bp%0d_res", i), bus.resp_res_o, 32'd3);
            @(negedge clk);
        end
        bus.resp_ready_i = 1'b1;
        #1;
        check("bp_release_ready", 32'(bus.req_ready_o), 32'b10);
        @(posedge clk);
        #1;
        check("bp_release_rvalid", 32'(bus.resp_valid_o), 32'd1);
        check("bp_release_id", 32'(bus.resp_id_o), 32'd1);
        check("bp_release_res", bus.resp_res_o, 32'd300);
        check("bp_busy", bus.busy_cnt_o, 32'd13);

        // Async reset between edges while a response is held (ptr=0 after last grant... then forced 0)
        @(negedge clk);
        drive(2'b00, 4'd0, 0, 1, 2, 4'd0, 100, 200);
        #2 reset = 1'b0;
        #1;
        check("arst_rvalid", 32'(bus.resp_valid_o), 32'd0);
        check("arst_res", bus.resp_res_o, 32'd0);
        check("arst_busy", bus.busy_cnt_o, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        drive(2'b11, 4'd0, 0, 1, 2, 4'd1, 10, 3);
        #1;
        check("arst_first_ready", 32'(bus.req_ready_o), 32'b01);
        @(posedge clk);
        #1;
        check("arst_first_id", 32'(bus.resp_id_o), 32'd0);
        check("arst_first_res", bus.resp_res_o, 32'd3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
